// File: rtl/prescaler_tap_sync.sv
// Run-time selectable 2^k prescaler producing a one-cycle clock-enable pulse.
// Tap changes are deferred to the active tap's period boundary so no runt period is emitted.
module prescaler_tap_sync #(
  parameter int NUM_TAPS  = 6,
  parameter int SEL_W     = 3,
  parameter int RESET_SEL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic             tick_o,
  output logic [SEL_W-1:0] active_sel_o,
  output logic             busy_o
);

  localparam int CNT_W = (NUM_TAPS > 1) ? NUM_TAPS - 1 : 1;
  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(NUM_TAPS - 1);
  localparam logic [SEL_W-1:0] RST_SEL = SEL_W'(RESET_SEL);

  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] act;
  logic [SEL_W-1:0] pend;
  logic [SEL_W-1:0] sel_clamped;
  logic [CNT_W:0]   mask_full;
  logic [CNT_W-1:0] mask;
  logic             hit;

  // The mask is built one bit wider so the largest tap (act == CNT_W) does not overflow.
  always_comb begin
    sel_clamped = (sel_i > MAX_SEL) ? MAX_SEL : sel_i;
    mask_full   = ((CNT_W + 1)'(1) << act) - (CNT_W + 1)'(1);
    mask        = mask_full[CNT_W-1:0];
    hit         = ((cnt & mask) == mask);
  end

  // NOTE: non-blocking assignments here so every register samples the pre-edge values of
  // act, pend and cnt; the boundary switch relies on reading the old pend.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      act    <= RST_SEL;
      pend   <= RST_SEL;
      tick_o <= 1'b0;
    end else begin
      pend <= sel_clamped;
      if (en_i) begin
        tick_o <= hit;
        if (hit && (pend != act)) begin
          act <= pend;
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        // Idle: nothing downstream is counting, so the switch can be applied at once.
        tick_o <= 1'b0;
        cnt    <= '0;
        act    <= pend;
      end
    end
  end

  assign active_sel_o = act;
  assign busy_o       = (pend != act);

endmodule
